// File: rtl/haraka_pkg.sv
// -----------------------------------------------------------------------------
// haraka_pkg
// Constants and types shared by the sponge byte serializer and deserializer.
//   HARAKA_BLOCK_WIDTH      : width of one squeezed sponge block (bits)
//   HARAKA_PACKET_WIDTH     : width of one stream packet (bits)
//   HARAKA_PACKETS_IN_INPUT : packets carried by one block
//   HARAKA_LEN_WIDTH        : width of a requested output length (packets)
//   ser_state_t             : serializer FSM states
// -----------------------------------------------------------------------------
package haraka_pkg;

  localparam int HARAKA_BLOCK_WIDTH      = 256;
  localparam int HARAKA_PACKET_WIDTH     = 8;
  localparam int HARAKA_PACKETS_IN_INPUT = HARAKA_BLOCK_WIDTH / HARAKA_PACKET_WIDTH;
  localparam int HARAKA_LEN_WIDTH        = 16;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    REQ      = 3'd1,
    WAIT_BLK = 3'd2,
    SHIFT    = 3'd3,
    FIN      = 3'd4
  } ser_state_t;

endpackage

// File: rtl/squeeze_serializer.sv
// -----------------------------------------------------------------------------
// squeeze_serializer
// Pulls 256-bit squeezed blocks from the sponge and emits a stream of exactly
// out_len packets, first packet = block_in[7:0] (LSB first).
//
// Ports:
//   clk          : clock, rising edge
//   clear        : asynchronous active-high reset
//   start        : one-cycle pulse, begins a run (only honoured in IDLE)
//   out_len      : packets to emit, sampled with an accepted start
//   squeeze_req  : one-cycle request for the next sponge block
//   block_in     : squeezed block
//   block_valid  : block_in valid
//   block_ready  : serializer accepts block_in this cycle
//   serial_out   : current packet
//   serial_valid : serial_out valid
//   serial_ready : consumer takes serial_out this cycle
//   busy         : run in progress (any state but IDLE)
//   done         : one-cycle pulse after the last packet has been taken
// -----------------------------------------------------------------------------
module squeeze_serializer
  import haraka_pkg::*;
#(
  parameter int IN_WIDTH             = HARAKA_BLOCK_WIDTH,
  parameter int OUT_WIDTH            = HARAKA_PACKET_WIDTH,
  parameter int PACKETS_IN_INPUT     = IN_WIDTH / OUT_WIDTH,
  parameter int PACKET_COUNTER_WIDTH = $clog2(PACKETS_IN_INPUT),
  parameter int LEN_WIDTH            = HARAKA_LEN_WIDTH
) (
  input  logic                 clk,
  input  logic                 clear,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] out_len,
  output logic                 squeeze_req,
  input  logic [IN_WIDTH-1:0]  block_in,
  input  logic                 block_valid,
  output logic                 block_ready,
  output logic [OUT_WIDTH-1:0] serial_out,
  output logic                 serial_valid,
  input  logic                 serial_ready,
  output logic                 busy,
  output logic                 done
);

  localparam logic [LEN_WIDTH-1:0]            LEN_ONE  = LEN_WIDTH'(1);
  localparam logic [PACKET_COUNTER_WIDTH-1:0] PKT_ONE  = PACKET_COUNTER_WIDTH'(1);
  localparam logic [PACKET_COUNTER_WIDTH-1:0] PKT_LAST = PACKET_COUNTER_WIDTH'(PACKETS_IN_INPUT - 1);

  ser_state_t                      state_q, state_d;
  logic [IN_WIDTH-1:0]             shreg_q, shreg_d;
  logic [LEN_WIDTH-1:0]            remaining_q, remaining_d;
  logic [PACKET_COUNTER_WIDTH-1:0] pkt_cnt_q, pkt_cnt_d;

  logic start_ok;
  logic blk_take;
  logic pkt_take;

  assign start_ok = (state_q == IDLE) && start;
  assign blk_take = (state_q == WAIT_BLK) && block_valid;
  assign pkt_take = (state_q == SHIFT) && serial_ready;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers: shift register and the two counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      shreg_q     <= '0;
      remaining_q <= '0;
      pkt_cnt_q   <= '0;
    end else begin
      shreg_q     <= shreg_d;
      remaining_q <= remaining_d;
      pkt_cnt_q   <= pkt_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          // A zero-length run still reports completion, but never asks the
          // sponge for a block.
          state_d = (out_len != '0) ? REQ : FIN;
        end
      end
      REQ:      state_d = WAIT_BLK;
      WAIT_BLK: if (block_valid) state_d = SHIFT;
      SHIFT: begin
        if (serial_ready) begin
          // Length exhaustion wins over block exhaustion so an exact multiple
          // of the block size finishes without a spurious extra request.
          if (remaining_q == LEN_ONE) begin
            state_d = FIN;
          end else if (pkt_cnt_q == PKT_LAST) begin
            state_d = REQ;
          end
        end
      end
      FIN:      state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath next values
  // ---------------------------------------------------------------------------
  always_comb begin
    shreg_d     = shreg_q;
    remaining_d = remaining_q;
    pkt_cnt_d   = pkt_cnt_q;
    if (start_ok && (out_len != '0)) begin
      remaining_d = out_len;
    end
    if (blk_take) begin
      shreg_d   = block_in;
      pkt_cnt_d = '0;
    end
    if (pkt_take) begin
      // Zero-filled right shift exposes the next packet at the bottom.
      shreg_d     = shreg_q >> OUT_WIDTH;
      remaining_d = remaining_q - LEN_ONE;
      pkt_cnt_d   = pkt_cnt_q + PKT_ONE;  // wraps at PACKETS_IN_INPUT
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs are pure decodes of the state so clear forces them low at once.
  // ---------------------------------------------------------------------------
  always_comb begin
    squeeze_req  = 1'b0;
    block_ready  = 1'b0;
    serial_valid = 1'b0;
    serial_out   = '0;
    done         = 1'b0;
    busy         = (state_q != IDLE);
    unique case (state_q)
      REQ:      squeeze_req = 1'b1;
      WAIT_BLK: block_ready = 1'b1;
      SHIFT: begin
        serial_valid = 1'b1;
        serial_out   = shreg_q[OUT_WIDTH-1:0];
      end
      FIN:      done = 1'b1;
      default:  ;
    endcase
  end

endmodule

// File: tb/tb_squeeze_serializer.sv
module tb_squeeze_serializer;

  logic         clk;
  logic         clear;
  logic         start;
  logic [15:0]  out_len;
  logic         squeeze_req;
  logic [255:0] block_in;
  logic         block_valid;
  logic         block_ready;
  logic [7:0]   serial_out;
  logic         serial_valid;
  logic         serial_ready;
  logic         busy;
  logic         done;

  int n_cmp;
  int n_bad;

  squeeze_serializer dut (
    .clk          (clk),
    .clear        (clear),
    .start        (start),
    .out_len      (out_len),
    .squeeze_req  (squeeze_req),
    .block_in     (block_in),
    .block_valid  (block_valid),
    .block_ready  (block_ready),
    .serial_out   (serial_out),
    .serial_valid (serial_valid),
    .serial_ready (serial_ready),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  typedef struct {
    string       tag;
    int          len;
    logic [15:0] rpat;      // serial_ready bit per valid cycle, cycled
    int          rlen;      // 0 = random serial_ready
    int          blk_mode;  // 0 = patterned blocks, 1 = random blocks
    int          vdelay;    // max extra cycles before block_valid
    int          exp_reqs;
    bit          inject;    // pulse start while shifting
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // Block n of a run: patterned mode gives byte i = i for the first block and
  // 0x80 + 0x20*(n-1) + i afterwards.
  function automatic logic [255:0] make_block(input int mode, input int n);
    logic [255:0] b;
    for (int i = 0; i < 32; i++) begin
      if (mode != 0)   b[8*i +: 8] = 8'($urandom);
      else if (n == 0) b[8*i +: 8] = 8'(i);
      else             b[8*i +: 8] = 8'(8'h80 + 32*(n-1) + i);
    end
    return b;
  endfunction

  task automatic run_job(input string tag, input int len, input logic [15:0] rpat,
                         input int rlen, input int blk_mode, input int vdelay,
                         input int exp_reqs, input bit inject);
    logic [255:0] blocks[$];
    logic [255:0] blk;
    logic [7:0]   got[$];
    logic [7:0]   prev_out;
    logic [7:0]   exp_b;
    int           xfer_cyc[$];
    int           req_cyc[$];
    int           c, nvalid, nblk, wait_cnt, done_cyc;
    bit           finished, stalled, accept_pending, injected;

    c = 1; nvalid = 0; nblk = 0; done_cyc = -1;
    finished = 0; stalled = 0; accept_pending = 0; injected = 0;
    wait_cnt = (vdelay > 0) ? $urandom_range(vdelay, 0) : 0;

    start   = 1'b1;
    out_len = 16'(len);
    tick();
    start   = 1'b0;
    out_len = 16'($urandom);

    while (!finished && c < 4000) begin
      if (squeeze_req) begin
        req_cyc.push_back(c);
        blocks.push_back(make_block(blk_mode, blocks.size()));
      end
      if (accept_pending) begin
        chk({tag, " valid_after_accept"}, 64'(serial_valid), 64'd1);
        accept_pending = 0;
      end
      if (stalled) begin
        chk({tag, " hold_valid"}, 64'(serial_valid), 64'd1);
        chk({tag, " hold_out"}, 64'(serial_out), 64'(prev_out));
        stalled = 0;
      end

      block_valid = 1'b0;
      block_in    = rand256();
      if (block_ready) begin
        if (wait_cnt > 0) begin
          wait_cnt--;
        end else begin
          block_valid    = 1'b1;
          block_in       = (nblk < blocks.size()) ? blocks[nblk] : '0;
          nblk++;
          accept_pending = 1;
          wait_cnt       = (vdelay > 0) ? $urandom_range(vdelay, 0) : 0;
        end
      end else if (blk_mode == 1 && $urandom_range(3, 0) == 0) begin
        block_valid = 1'b1;  // must be ignored outside WAIT_BLK
      end

      if (serial_valid) begin
        serial_ready = (rlen == 0) ? 1'($urandom_range(1, 0)) : rpat[nvalid % rlen];
        nvalid++;
        if (serial_ready) begin
          got.push_back(serial_out);
          xfer_cyc.push_back(c);
        end else begin
          stalled  = 1;
          prev_out = serial_out;
        end
        if (inject && !injected && got.size() == 1) begin
          start    = 1'b1;
          out_len  = 16'd7;
          injected = 1;
        end
      end else begin
        serial_ready = 1'($urandom_range(1, 0));
      end

      if (done) begin
        finished = 1;
        done_cyc = c;
      end
      tick();
      c++;
      start = 1'b0;
    end
    block_valid  = 1'b0;
    serial_ready = 1'b0;

    chk({tag, " done_seen"}, 64'(finished), 64'd1);
    chk({tag, " idle_busy"}, 64'(busy), 64'd0);
    chk({tag, " done_single"}, 64'(done), 64'd0);
    chk({tag, " req_count"}, 64'(req_cyc.size()), 64'(exp_reqs));
    chk({tag, " xfer_count"}, 64'(got.size()), 64'(len));

    if (len > 0) begin
      if (req_cyc.size() > 0) chk({tag, " req_latency"}, 64'(req_cyc[0]), 64'd1);
      if (xfer_cyc.size() > 0)
        chk({tag, " done_latency"}, 64'(done_cyc), 64'(xfer_cyc[xfer_cyc.size()-1] + 1));
    end else begin
      chk({tag, " done_latency0"}, 64'(done_cyc), 64'd1);
      chk({tag, " no_valid"}, 64'(nvalid), 64'd0);
    end

    for (int k = 1; k < req_cyc.size(); k++) begin
      if (32*k - 1 < xfer_cyc.size())
        chk({tag, " req_after_block"}, 64'(req_cyc[k]), 64'(xfer_cyc[32*k-1] + 1));
    end

    // Reference stream: concatenation of the supplied blocks, LSB byte first,
    // truncated to the requested length.
    for (int k = 0; k < len && k < got.size(); k++) begin
      if (k / 32 < blocks.size()) begin
        blk   = blocks[k/32];
        exp_b = blk[8*(k%32) +: 8];
        chk({tag, " byte"}, 64'(got[k]), 64'(exp_b));
      end
    end

    $display("job %s len=%0d transfers=%0d requests=%0d done_cycle=%0d",
             tag, len, got.size(), req_cyc.size(), done_cyc);
  endtask

  vec_t tbl[10];

  initial begin
    int xfers;
    int len;
    bit seen_done;

    n_cmp = 0; n_bad = 0;
    clear = 1'b0; start = 1'b0; out_len = '0;
    block_in = '0; block_valid = 1'b0; serial_ready = 1'b0;

    tbl[0] = '{"len4",      4, 16'h1,      1, 0, 0, 1, 0};
    tbl[1] = '{"len40",    40, 16'h1,      1, 0, 0, 2, 0};
    tbl[2] = '{"len32",    32, 16'h1,      1, 0, 0, 1, 0};
    tbl[3] = '{"stall3",    3, 16'b101001, 6, 0, 0, 1, 0};
    tbl[4] = '{"len0",      0, 16'h1,      1, 0, 0, 0, 0};
    tbl[5] = '{"ign_start", 4, 16'h1,      1, 0, 0, 1, 1};
    tbl[6] = '{"len33",    33, 16'h0,      0, 1, 2, 2, 0};
    tbl[7] = '{"len64",    64, 16'h0,      0, 1, 2, 2, 0};
    tbl[8] = '{"len65",    65, 16'h0,      0, 1, 3, 3, 0};
    tbl[9] = '{"len1",      1, 16'h0,      0, 1, 1, 1, 0};

    // Reset state
    #3 clear = 1'b1;
    #4;
    chk("rst squeeze_req", 64'(squeeze_req), 64'd0);
    chk("rst block_ready", 64'(block_ready), 64'd0);
    chk("rst serial_out", 64'(serial_out), 64'd0);
    chk("rst serial_valid", 64'(serial_valid), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst done", 64'(done), 64'd0);
    tick();
    clear = 1'b0;
    tick();

    for (int i = 0; i < 10; i++) begin
      run_job(tbl[i].tag, tbl[i].len, tbl[i].rpat, tbl[i].rlen, tbl[i].blk_mode,
              tbl[i].vdelay, tbl[i].exp_reqs, tbl[i].inject);
      tick();
    end

    // Clear during SHIFT after five transfers
    start = 1'b1; out_len = 16'd40;
    tick();
    start = 1'b0;
    xfers = 0;
    for (int c = 0; c < 60 && xfers < 5; c++) begin
      block_valid  = block_ready;
      block_in     = make_block(0, 0);
      serial_ready = 1'b1;
      if (serial_valid) xfers++;
      tick();
    end
    block_valid = 1'b0;
    chk("clr pre_valid", 64'(serial_valid), 64'd1);
    chk("clr pre_out", 64'(serial_out), 64'h05);
    #2 clear = 1'b1;
    #1;
    chk("clr squeeze_req", 64'(squeeze_req), 64'd0);
    chk("clr block_ready", 64'(block_ready), 64'd0);
    chk("clr serial_out", 64'(serial_out), 64'd0);
    chk("clr serial_valid", 64'(serial_valid), 64'd0);
    chk("clr busy", 64'(busy), 64'd0);
    chk("clr done", 64'(done), 64'd0);
    tick();
    clear = 1'b0;
    seen_done = 0;
    for (int c = 0; c < 8; c++) begin
      if (done || busy) seen_done = 1;
      tick();
    end
    chk("clr no_done", 64'(seen_done), 64'd0);
    run_job("after_clear", 2, 16'h1, 1, 0, 0, 1, 0);
    tick();

    // Randomized runs against the stream model
    for (int r = 0; r < 12; r++) begin
      case ($urandom_range(3, 0))
        0:       len = 32 * $urandom_range(3, 1) + $urandom_range(2, 0) - 1;
        default: len = $urandom_range(100, 0);
      endcase
      run_job($sformatf("rand%0d", r), len, 16'h0, 0, 1, 3, (len + 31) / 32,
              1'($urandom_range(1, 0)));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/squeeze_serializer.md
Name: squeeze_serializer

Overview:
- Downstream stage of the SHAKE256/Haraka sponge: consumes 256-bit squeezed output blocks and emits them as a byte stream of a caller-requested length.
- Requests each block with a one-cycle `squeeze_req`, accepts it on a valid/ready handshake, then shifts out bytes LSB-first under `serial_ready` backpressure.
- Byte order mirrors the upstream byte deserializer: the first byte out is `block_in[7:0]`.

Parameters:
- IN_WIDTH, 256, width of one squeezed block
- OUT_WIDTH, 8, width of one output packet
- PACKETS_IN_INPUT, IN_WIDTH/OUT_WIDTH (32), packets per block
- PACKET_COUNTER_WIDTH, $clog2(PACKETS_IN_INPUT), packet index width
- LEN_WIDTH, 16, width of the requested output length in packets

Ports:
- clk  in  1  single clock, rising edge
- clear  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse: begin an output run of out_len packets
- out_len  in  LEN_WIDTH  packets requested; sampled only when start is accepted
- squeeze_req  out  1  one-cycle pulse asking the sponge for the next block
- block_in  in  IN_WIDTH  squeezed block
- block_valid  in  1  block_in is valid
- block_ready  out  1  serializer will accept block_in this cycle
- serial_out  out  OUT_WIDTH  current output packet
- serial_valid  out  1  serial_out is valid
- serial_ready  in  1  consumer accepts serial_out this cycle
- busy  out  1  run in progress; high in every state except IDLE
- done  out  1  one-cycle pulse after the last packet is transferred

Behaviour:
- Reset: `clear` takes effect immediately (asynchronous) and overrides everything.
  - State returns to IDLE.
  - shreg, remaining and pkt_cnt clear to 0.
  - All outputs are 0: squeeze_req, block_ready, serial_out, serial_valid, busy, done.
- FSM states: IDLE, REQ, WAIT_BLK, SHIFT, FIN. Transitions:
  - IDLE: if start and out_len != 0: latch remaining = out_len, go to REQ.
  - IDLE: if start and out_len == 0: go to FIN (no request is issued).
  - REQ: squeeze_req = 1 for exactly this cycle; go to WAIT_BLK next cycle.
  - WAIT_BLK: block_ready = 1. On block_valid, shreg <= block_in, pkt_cnt <= 0, go to SHIFT.
  - SHIFT: serial_valid = 1, serial_out = shreg[OUT_WIDTH-1:0]. On a transfer (serial_valid & serial_ready):
    - shreg shifts right by OUT_WIDTH, zero-filled;
    - remaining decrements and pkt_cnt increments;
    - if remaining == 1, go to FIN;
    - else if pkt_cnt == PACKETS_IN_INPUT-1 (wraps to 0), go to REQ;
    - else stay in SHIFT.
  - FIN: done = 1 for exactly this cycle; go to IDLE.
- Latency:
  - start at cycle 0 gives squeeze_req at cycle 1.
  - Block accepted at cycle t gives serial_valid at cycle t+1.
  - Last transfer at cycle u gives done at cycle u+1.
- Backpressure: while serial_valid & !serial_ready, serial_out and shreg hold stable and no counter changes.
- Ignored inputs:
  - start outside IDLE is ignored and does not relatch out_len.
  - block_valid outside WAIT_BLK is ignored; block_ready is low there.
- Partial final block: when out_len is not a multiple of 32, the unused packets of the last block are discarded and no extra squeeze_req is issued.
- Width rules: remaining is LEN_WIDTH bits and never underflows (FIN is entered at 1). pkt_cnt is PACKET_COUNTER_WIDTH bits and wraps naturally at 32.
- Reset mid-run: asserting clear mid-run abandons the run; no done pulse is produced.

Decomposition:
- haraka_pkg (shared package) holds:
  - the state enum `ser_state_t`;
  - the block and packet width constants (256, 8) and derived PACKETS_IN_INPUT, used jointly with the deserializer.
- No sub-module. One FSM plus a shift register and two counters, in a single module (~150-200 lines).

Test Plan:
- Block byte i = i (0x00..0x1F), out_len=4, serial_ready=1 -> one squeeze_req; serial_out 0x00,0x01,0x02,0x03 on 4 consecutive cycles; done 1 cycle after 0x03; remaining bytes discarded.
- out_len=40, block A bytes = i, block B bytes = 0x80+i -> squeeze_req twice; 0x00..0x1F, second squeeze_req the cycle after 0x1F, then 0x80..0x87; done; exactly 40 transfers.
- out_len=32 -> exactly one squeeze_req; done after 0x1F with no second request (boundary: remaining==1 coincides with pkt_cnt==31).
- out_len=3, serial_ready pattern 1,0,0,1,0,1 -> serial_out held at 0x01 through the stalls; transfers 0x00,0x01,0x02 only on ready cycles; done afterwards.
- out_len=0 -> done the cycle after start, no squeeze_req, serial_valid never high; start pulsed while in SHIFT is ignored (transfer count unchanged).
- Assert clear during SHIFT after 5 bytes -> all outputs 0 immediately; busy low; no done pulse; a new start with out_len=2 then runs normally from REQ.
